// File: rtl/mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb_writeback
// Description : MEM/WB pipeline register and writeback stage. Latches the MEM
//               stage results and selects the value written back. Drives the
//               register-file write port (wb_id_*). Tracks HALT retirement with
//               a RUN/HALTED state machine. Exports a forwarding-valid flag.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : W  datapath width, RA register address width
// Ports       : clock, reset (sync, active-low)
//               hold, flush            hazard-unit controls (flush > hold)
//               mem_*                  MEM-stage instruction fields
//               wb_id_*                register-file write port
//               wb_fwd_valid           forwarding source valid
//               wb_halted              HALT has retired
//               wb_retired             retired count (WB_RETIRE_COUNT_EN only)
// Config      : define WB_RETIRE_COUNT_EN to build the retired-instruction
//               counter and its wb_retired port.
// ============================================================================
module mem_wb_writeback #(
    parameter int W  = 16,
    parameter int RA = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          hold,
    input  logic          flush,
    input  logic          mem_valid,
    input  logic          mem_reg_write,
    input  logic          mem_write_r0,
    input  logic [1:0]    mem_wb_sel,
    input  logic          mem_byte_load,
    input  logic          mem_halt,
    input  logic [RA-1:0] mem_write_reg,
    input  logic [W-1:0]  mem_alu_result,
    input  logic [W-1:0]  mem_alu_r0,
    input  logic [W-1:0]  mem_read_data,
    input  logic [W-1:0]  mem_pc_next,
    output logic [RA-1:0] wb_id_write_reg,
    output logic [W-1:0]  wb_id_write_data,
    output logic [W-1:0]  wb_id_r0,
    output logic          wb_id_reg_write_control,
    output logic          wb_id_write_r0,
    output logic          wb_fwd_valid,
    output logic          wb_halted
`ifdef WB_RETIRE_COUNT_EN
    ,
    output logic [W-1:0]  wb_retired
`endif
);

    localparam logic [1:0] C_SEL_LOAD = 2'b01;
    localparam logic [1:0] C_SEL_LINK = 2'b10;

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // MEM/WB pipeline register fields
    logic          r_valid;
    logic          r_reg_write;
    logic          r_write_r0;
    logic [1:0]    r_wb_sel;
    logic          r_byte_load;
    logic          r_halt;
    logic [RA-1:0] r_write_reg;
    logic [W-1:0]  r_alu_result;
    logic [W-1:0]  r_alu_r0;
    logic [W-1:0]  r_read_data;
    logic [W-1:0]  r_pc_next;

    logic          w_run;
    logic          w_reg_we;
    logic          w_r0_we;
    logic          w_r0_conflict;
    logic [W-1:0]  w_load_data;

    assign w_run = (r_state == ST_RUN);

    // ------------------------------------------------------------------------
    // Pipeline register. Once halted the stage is frozen; only reset leaves it.
    // A flush clears every field, so stale data never appears on the port.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset || (w_run && flush)) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_write_r0   <= 1'b0;
            r_wb_sel     <= 2'b00;
            r_byte_load  <= 1'b0;
            r_halt       <= 1'b0;
            r_write_reg  <= '0;
            r_alu_result <= '0;
            r_alu_r0     <= '0;
            r_read_data  <= '0;
            r_pc_next    <= '0;
        end else if (w_run && !hold) begin
            r_valid      <= mem_valid;
            r_reg_write  <= mem_reg_write;
            r_write_r0   <= mem_write_r0;
            r_wb_sel     <= mem_wb_sel;
            r_byte_load  <= mem_byte_load;
            r_halt       <= mem_halt;
            r_write_reg  <= mem_write_reg;
            r_alu_result <= mem_alu_result;
            r_alu_r0     <= mem_alu_r0;
            r_read_data  <= mem_read_data;
            r_pc_next    <= mem_pc_next;
        end
    end

    // ------------------------------------------------------------------------
    // RUN/HALTED state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN: begin
                if (r_valid && r_halt) begin
                    w_state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Writeback data select and write enables
    // ------------------------------------------------------------------------
    assign w_load_data = r_byte_load ? {{(W-8){r_read_data[7]}}, r_read_data[7:0]}
                                     : r_read_data;

    always_comb begin
        wb_id_write_data = r_alu_result;
        case (r_wb_sel)
            C_SEL_LOAD: wb_id_write_data = w_load_data;
            C_SEL_LINK: wb_id_write_data = r_pc_next;
            default:    wb_id_write_data = r_alu_result;
        endcase
    end

    // An R0 write and a normal write targeting R0 would collide on the same
    // register; the dedicated R0 port carries the intended value.
    assign w_r0_conflict = (r_write_reg == '0) && r_write_r0;
    assign w_r0_we       = r_valid && r_write_r0 && !r_halt && w_run;
    assign w_reg_we      = r_valid && r_reg_write && !r_halt && w_run && !w_r0_conflict;

    assign wb_id_write_reg         = r_write_reg;
    assign wb_id_r0                = r_alu_r0;
    assign wb_id_reg_write_control = w_reg_we;
    assign wb_id_write_r0          = w_r0_we;
    assign wb_fwd_valid            = w_reg_we || w_r0_we;
    assign wb_halted               = (r_state == ST_HALTED);

`ifdef WB_RETIRE_COUNT_EN
    // An instruction retires when it leaves WB; a held instruction is
    // counted only on the edge it finally moves on.
    localparam logic [W-1:0] C_ONE = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] r_retired;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_retired <= '0;
        end else if (r_valid && !hold && w_run) begin
            r_retired <= r_retired + C_ONE;
        end
    end

    assign wb_retired = r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_wb_writeback
// Description : Self-checking bench for mem_wb_writeback: reset state, a table
//               of writeback vectors, hold/flush/halt sequences and randomized
//               traffic against a behavioural model of the stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_writeback;

    logic        clock = 1'b0;
    logic        reset, hold, flush;
    logic        mem_valid, mem_reg_write, mem_write_r0, mem_byte_load, mem_halt;
    logic [1:0]  mem_wb_sel;
    logic [3:0]  mem_write_reg;
    logic [15:0] mem_alu_result, mem_alu_r0, mem_read_data, mem_pc_next;
    logic [3:0]  wb_id_write_reg;
    logic [15:0] wb_id_write_data, wb_id_r0;
    logic        wb_id_reg_write_control, wb_id_write_r0, wb_fwd_valid, wb_halted;
`ifdef WB_RETIRE_COUNT_EN
    logic [15:0] wb_retired;
`endif

    mem_wb_writeback #(.W(16), .RA(4)) dut (
        .clock                   (clock),
        .reset                   (reset),
        .hold                    (hold),
        .flush                   (flush),
        .mem_valid               (mem_valid),
        .mem_reg_write           (mem_reg_write),
        .mem_write_r0            (mem_write_r0),
        .mem_wb_sel              (mem_wb_sel),
        .mem_byte_load           (mem_byte_load),
        .mem_halt                (mem_halt),
        .mem_write_reg           (mem_write_reg),
        .mem_alu_result          (mem_alu_result),
        .mem_alu_r0              (mem_alu_r0),
        .mem_read_data           (mem_read_data),
        .mem_pc_next             (mem_pc_next),
        .wb_id_write_reg         (wb_id_write_reg),
        .wb_id_write_data        (wb_id_write_data),
        .wb_id_r0                (wb_id_r0),
        .wb_id_reg_write_control (wb_id_reg_write_control),
        .wb_id_write_r0          (wb_id_write_r0),
        .wb_fwd_valid            (wb_fwd_valid),
        .wb_halted               (wb_halted)
`ifdef WB_RETIRE_COUNT_EN
        ,
        .wb_retired              (wb_retired)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst_n, hold, flush;
        logic        valid, reg_write, write_r0;
        logic [1:0]  sel;
        logic        byte_load, halt;
        logic [3:0]  wreg;
        logic [15:0] alu, r0, rd, pc;
    } in_t;

    typedef struct {
        logic        valid, reg_write, write_r0;
        logic [1:0]  sel;
        logic        byte_load;
        logic [3:0]  wreg;
        logic [15:0] alu, r0, rd, pc;
        logic        e_we, e_wr0;
        logic [3:0]  e_reg;
        logic [15:0] e_data, e_r0;
    } vec_t;

    int n_cmp = 0;
    int n_mis = 0;

    // Behavioural model: the instruction sitting in WB, halted flag, count.
    in_t         lat;
    bit          m_halted;
    logic [15:0] m_cnt;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic in_t idle();
        in_t c;
        c = '{default: '0};
        c.rst_n = 1'b1;
        return c;
    endfunction

    task automatic drive_and_step(input in_t c);
        reset = c.rst_n; hold = c.hold; flush = c.flush;
        mem_valid = c.valid; mem_reg_write = c.reg_write; mem_write_r0 = c.write_r0;
        mem_wb_sel = c.sel; mem_byte_load = c.byte_load; mem_halt = c.halt;
        mem_write_reg = c.wreg; mem_alu_result = c.alu; mem_alu_r0 = c.r0;
        mem_read_data = c.rd; mem_pc_next = c.pc;
        if (!c.rst_n) begin
            lat = '{default: '0};
            m_halted = 1'b0;
            m_cnt = 16'h0000;
        end else if (!m_halted) begin
            if (lat.valid && !c.hold) m_cnt = m_cnt + 16'd1;
            if (lat.valid && lat.halt) m_halted = 1'b1;
            if (c.flush) lat.valid = 1'b0;
            else if (!c.hold) lat = c;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic compare_model();
        logic        we, wr0;
        logic [15:0] data;
        wr0 = lat.valid && lat.write_r0 && !lat.halt && !m_halted;
        we  = lat.valid && lat.reg_write && !lat.halt && !m_halted
              && !(lat.wreg == 4'd0 && lat.write_r0);
        if (lat.sel == 2'd1)
            data = !lat.byte_load ? lat.rd
                 : (lat.rd[7] ? (16'hFF00 | (lat.rd & 16'h00FF)) : (lat.rd & 16'h00FF));
        else if (lat.sel == 2'd2)
            data = lat.pc;
        else
            data = lat.alu;
        check("model_we",     {15'd0, wb_id_reg_write_control}, {15'd0, we});
        check("model_wr0",    {15'd0, wb_id_write_r0},          {15'd0, wr0});
        check("model_fwd",    {15'd0, wb_fwd_valid},            {15'd0, we || wr0});
        check("model_halted", {15'd0, wb_halted},               {15'd0, m_halted});
        if (we) begin
            check("model_reg",  {12'd0, wb_id_write_reg}, {12'd0, lat.wreg});
            check("model_data", wb_id_write_data, data);
        end
        if (wr0) check("model_r0", wb_id_r0, lat.r0);
`ifdef WB_RETIRE_COUNT_EN
        check("model_cnt", wb_retired, m_cnt);
`endif
    endtask

    task automatic cycle(input in_t c);
        drive_and_step(c);
        compare_model();
    endtask

    function automatic in_t add(input logic [3:0] r, input logic [15:0] v);
        in_t c;
        c = idle();
        c.valid = 1'b1; c.reg_write = 1'b1; c.wreg = r; c.alu = v;
        return c;
    endfunction

    vec_t vecs[12];

    initial begin
        in_t c;
        lat = '{default: '0};
        m_halted = 1'b0;
        m_cnt = 16'h0000;

        //        v  rw r0 sel bl reg  alu      r0       rd       pc       we wr0 ereg edata    er0
        vecs[0]  = '{1, 1, 0, 0, 0, 3,  16'h1234,16'h0000,16'h0000,16'h0000, 1, 0, 3,  16'h1234,16'h0000};
        vecs[1]  = '{1, 1, 0, 1, 1, 4,  16'h0000,16'h0000,16'h0080,16'h0000, 1, 0, 4,  16'hFF80,16'h0000};
        vecs[2]  = '{1, 1, 0, 1, 1, 4,  16'h0000,16'h0000,16'h007F,16'h0000, 1, 0, 4,  16'h007F,16'h0000};
        vecs[3]  = '{1, 1, 0, 1, 0, 8,  16'h0000,16'h0000,16'h8081,16'h0000, 1, 0, 8,  16'h8081,16'h0000};
        vecs[4]  = '{1, 1, 0, 1, 1, 9,  16'h0000,16'h0000,16'h12F5,16'h0000, 1, 0, 9,  16'hFFF5,16'h0000};
        vecs[5]  = '{1, 1, 0, 2, 0, 15, 16'hAAAA,16'h0000,16'h0000,16'h0102, 1, 0, 15, 16'h0102,16'h0000};
        vecs[6]  = '{1, 1, 0, 3, 0, 6,  16'h5555,16'h0000,16'h7777,16'h0000, 1, 0, 6,  16'h5555,16'h0000};
        vecs[7]  = '{1, 1, 1, 0, 0, 0,  16'h0001,16'hABCD,16'h0000,16'h0000, 0, 1, 0,  16'h0000,16'hABCD};
        vecs[8]  = '{1, 0, 0, 0, 0, 7,  16'h4321,16'h0000,16'h0000,16'h0000, 0, 0, 0,  16'h0000,16'h0000};
        vecs[9]  = '{1, 1, 1, 0, 0, 2,  16'h00AA,16'h00BB,16'h0000,16'h0000, 1, 1, 2,  16'h00AA,16'h00BB};
        vecs[10] = '{0, 1, 1, 0, 0, 5,  16'h1111,16'h2222,16'h0000,16'h0000, 0, 0, 0,  16'h0000,16'h0000};
        vecs[11] = '{1, 0, 1, 0, 0, 0,  16'h0000,16'hC0DE,16'h0000,16'h0000, 0, 1, 0,  16'h0000,16'hC0DE};

        // Reset held low for two cycles: every output zero.
        c = idle(); c.rst_n = 1'b0;
        cycle(c);
        cycle(c);
        check("rst_reg",    {12'd0, wb_id_write_reg}, 16'h0000);
        check("rst_data",   wb_id_write_data, 16'h0000);
        check("rst_r0",     wb_id_r0, 16'h0000);
        check("rst_en",     {13'd0, wb_id_reg_write_control, wb_id_write_r0, wb_fwd_valid}, 16'h0000);
        check("rst_halted", {15'd0, wb_halted}, 16'h0000);

        // Table of writeback vectors, one instruction per cycle.
        for (int i = 0; i < 12; i++) begin
            c = idle();
            c.valid = vecs[i].valid; c.reg_write = vecs[i].reg_write;
            c.write_r0 = vecs[i].write_r0; c.sel = vecs[i].sel;
            c.byte_load = vecs[i].byte_load; c.wreg = vecs[i].wreg;
            c.alu = vecs[i].alu; c.r0 = vecs[i].r0; c.rd = vecs[i].rd; c.pc = vecs[i].pc;
            cycle(c);
            check($sformatf("vec%0d_we", i),  {15'd0, wb_id_reg_write_control}, {15'd0, vecs[i].e_we});
            check($sformatf("vec%0d_wr0", i), {15'd0, wb_id_write_r0}, {15'd0, vecs[i].e_wr0});
            if (vecs[i].e_we) begin
                check($sformatf("vec%0d_reg", i),  {12'd0, wb_id_write_reg}, {12'd0, vecs[i].e_reg});
                check($sformatf("vec%0d_data", i), wb_id_write_data, vecs[i].e_data);
            end
            if (vecs[i].e_wr0) check($sformatf("vec%0d_r0", i), wb_id_r0, vecs[i].e_r0);
        end

        // Hold three cycles with ADD R5 latched, then flush+hold together.
        cycle(add(4'd5, 16'h0555));
        for (int i = 0; i < 3; i++) begin
            c = add(4'd9, 16'hFFFF); c.hold = 1'b1;
            cycle(c);
            check("hold_we",   {15'd0, wb_id_reg_write_control}, 16'h0001);
            check("hold_reg",  {12'd0, wb_id_write_reg}, 16'h0005);
            check("hold_data", wb_id_write_data, 16'h0555);
        end
        c = add(4'd9, 16'hFFFF); c.hold = 1'b1; c.flush = 1'b1;
        cycle(c);
        check("flush_we",  {15'd0, wb_id_reg_write_control}, 16'h0000);
        check("flush_fwd", {15'd0, wb_fwd_valid}, 16'h0000);

        // Reset while holding: no residual write.
        cycle(add(4'd6, 16'h0666));
        c = add(4'd7, 16'h0777); c.hold = 1'b1; c.rst_n = 1'b0;
        cycle(c);
        check("rst_hold_we", {15'd0, wb_id_reg_write_control}, 16'h0000);

        // HALT retires, later writes are suppressed until reset.
        c = add(4'd1, 16'h0101); c.halt = 1'b1;
        cycle(c);
        check("halt_we", {15'd0, wb_id_reg_write_control}, 16'h0000);
        cycle(add(4'd2, 16'h0202));
        check("halted", {15'd0, wb_halted}, 16'h0001);
        for (int i = 0; i < 3; i++) begin
            cycle(add(4'd2, 16'h0202));
            check("halted_we",  {15'd0, wb_id_reg_write_control}, 16'h0000);
            check("halted_fwd", {15'd0, wb_fwd_valid}, 16'h0000);
        end
        c = add(4'd2, 16'h0202); c.rst_n = 1'b0;
        cycle(c);
        check("unhalt", {15'd0, wb_halted}, 16'h0000);
        check("unhalt_we", {15'd0, wb_id_reg_write_control}, 16'h0000);
        cycle(add(4'd2, 16'h0202));
        check("resume_we", {15'd0, wb_id_reg_write_control}, 16'h0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            c.rst_n     = ($urandom_range(0, 39) != 0);
            c.hold      = ($urandom_range(0, 4) == 0);
            c.flush     = ($urandom_range(0, 7) == 0);
            c.valid     = ($urandom_range(0, 3) != 0);
            c.reg_write = $urandom_range(0, 1);
            c.write_r0  = ($urandom_range(0, 3) == 0);
            c.sel       = 2'($urandom_range(0, 3));
            c.byte_load = $urandom_range(0, 1);
            c.halt      = ($urandom_range(0, 24) == 0);
            c.wreg      = 4'($urandom_range(0, 15));
            c.alu       = 16'($urandom);
            c.r0        = 16'($urandom);
            c.rd        = 16'($urandom);
            c.pc        = 16'($urandom);
            cycle(c);
        end

`ifdef WB_RETIRE_COUNT_EN
        // Counter wrap: 65535 retires then one more.
        c = idle(); c.rst_n = 1'b0;
        cycle(c);
        c = idle(); c.valid = 1'b1;
        for (int i = 0; i < 65536; i++) drive_and_step(c);
        check("cnt_ffff", wb_retired, 16'hFFFF);
        drive_and_step(c);
        check("cnt_wrap", wb_retired, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
